// File: rtl/blink_pkg.sv
// Shared types and helpers for the per-digit anode blink controller.
//   blink_mode_t  : decoded mode input (off / slow / fast / burst)
//   blink_state_t : controller FSM state
//   max_u         : larger of two unsigned values, used to size the prescaler
package blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_SLOW  = 2'b01,
    MODE_FAST  = 2'b10,
    MODE_BURST = 2'b11
  } blink_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHOW  = 2'b01,
    ST_BLANK = 2'b10
  } blink_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Half-period prescaler for the blink controller.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force count to zero (takes priority over enable)
//   enable   : advance count by one per cycle
//   term     : runtime terminal value (DIV-1)
//   tc       : one-cycle pulse while count == term and enabled; count restarts at zero
module blink_prescaler #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            enable,
  input  logic [CntW-1:0] term,
  output logic            tc
);

  logic [CntW-1:0] count_q, count_d;

  // Terminal compare only; the counter never runs past term.
  assign tc = enable && !clear && (count_q == term);

  always_comb begin
    count_d = count_q;
    if (clear || tc) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/blink_anode_ctrl.sv
// Per-digit blink controller between the digit multiplexer and the anode pins.
// Masked digits are blanked (anode forced to 1, active-low) in slow, fast or
// counted-burst patterns timed by an internal prescaler.
//   clk, rst     : clock, asynchronous active-high reset
//   anode_in     : active-low anodes from the digit mux
//   blink_mask   : 1 = digit takes part in blinking
//   mode         : 00 off, 01 slow, 10 fast, 11 burst
//   start        : one-cycle pulse launching a burst (burst mode, not busy)
//   burst_count  : number of blank phases in a burst, sampled on start
//   anode_out    : registered active-low anodes to the pins
//   blank_phase  : 1 while masked digits are blanked
//   busy         : 1 while a burst runs
//   done         : one-cycle pulse when a burst completes
module blink_anode_ctrl
  import blink_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SLOW_DIV   = 50_000_000,
  parameter int unsigned FAST_DIV   = 12_500_000,
  parameter int unsigned BURST_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] anode_in,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic [BURST_W-1:0]    burst_count,
  output logic [NUM_DIGITS-1:0] anode_out,
  output logic                  blank_phase,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntLog = $clog2(max_u(SLOW_DIV, FAST_DIV));
  localparam int unsigned CntW   = (CntLog > 0) ? CntLog : 1;

  blink_mode_t  mode_e, mode_q;
  blink_state_t state_q, state_d;
  logic [BURST_W-1:0]    remaining_q, remaining_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NUM_DIGITS-1:0] anode_q;
  logic                  mode_chg;
  logic                  psc_clear, psc_enable, psc_tc;
  logic [CntW-1:0]       psc_term;

  assign mode_e   = blink_mode_t'(mode);
  assign mode_chg = (mode_e != mode_q);

  // Burst phases share the fast half-period.
  assign psc_term   = (mode_e == MODE_SLOW) ? CntW'(SLOW_DIV - 1) : CntW'(FAST_DIV - 1);
  assign psc_enable = (state_q == ST_SHOW) || (state_q == ST_BLANK);
  assign psc_clear  = (state_q == ST_IDLE) || mode_chg;

  blink_prescaler #(
    .CntW (CntW)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (psc_clear),
    .enable (psc_enable),
    .term   (psc_term),
    .tc     (psc_tc)
  );

  // State register plus burst bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_OFF;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_e;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    if (mode_chg) begin
      // Any mode change aborts; an aborted burst gives no done pulse.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if ((mode_e == MODE_SLOW) || (mode_e == MODE_FAST)) begin
            state_d = ST_SHOW;
          end else if ((mode_e == MODE_BURST) && start && !busy_q) begin
            if (burst_count != '0) begin
              state_d     = ST_BLANK;
              remaining_d = burst_count;
              busy_d      = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_SHOW: begin
          if (psc_tc) begin
            state_d = ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (psc_tc) begin
            if (mode_e == MODE_BURST) begin
              if (remaining_q <= BURST_W'(1)) begin
                state_d     = ST_IDLE;
                remaining_d = '0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
              end else begin
                state_d     = ST_SHOW;
                remaining_d = remaining_q - BURST_W'(1);
              end
            end else begin
              state_d = ST_SHOW;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    blank_phase = (state_q == ST_BLANK);
    busy        = busy_q;
    done        = done_q;
    anode_out   = anode_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_q <= '1;
    end else begin
      anode_q <= anode_in | ({NUM_DIGITS{blank_phase}} & blink_mask);
    end
  end

endmodule

// File: tb/tb_blink_anode_ctrl.sv
module tb_blink_anode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] anode_in;
  logic [3:0] blink_mask;
  logic [1:0] mode;
  logic       start;
  logic [3:0] burst_count;
  logic [3:0] anode_out;
  logic       blank_phase;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  blink_anode_ctrl #(
    .NUM_DIGITS (4),
    .SLOW_DIV   (8),
    .FAST_DIV   (2),
    .BURST_W    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .anode_in    (anode_in),
    .blink_mask  (blink_mask),
    .mode        (mode),
    .start       (start),
    .burst_count (burst_count),
    .anode_out   (anode_out),
    .blank_phase (blank_phase),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nblank;
    logic prev_blank;
    rst         = 1'b1;
    anode_in    = 4'b0000;
    blink_mask  = 4'b0000;
    mode        = 2'b00;
    start       = 1'b0;
    burst_count = 4'd0;

    // 1: reset values, then pass-through after release
    repeat (3) tick();
    check("rst_anode", 32'(anode_out), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_blank", 32'(blank_phase), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_anode", 32'(anode_out), 32'h0);

    // 2: mode OFF, full mask -> pure pass-through
    anode_in   = 4'b1010;
    blink_mask = 4'b1111;
    tick();
    for (int k = 0; k < 100; k++) begin
      check("off_anode", 32'(anode_out), 32'hA);
      tick();
    end

    // 3: SLOW blink, mask 0011; blank_phase high after edges 10..17, 26..33
    mode       = 2'b01;
    anode_in   = 4'b0000;
    blink_mask = 4'b0011;
    for (int k = 1; k <= 34; k++) begin
      tick();
      check("slow_blank", 32'(blank_phase),
            ((k >= 10 && k <= 17) || (k >= 26 && k <= 33)) ? 32'd1 : 32'd0);
      check("slow_anode", 32'(anode_out),
            ((k >= 11 && k <= 18) || (k >= 27 && k <= 34)) ? 32'h3 : 32'h0);
    end

    // 4: burst of 3; a second start while busy is ignored
    mode = 2'b11;
    repeat (3) tick();
    check("bidle_busy", 32'(busy), 32'd0);
    check("bidle_blank", 32'(blank_phase), 32'd0);
    check("bidle_anode", 32'(anode_out), 32'h0);
    start       = 1'b1;
    burst_count = 4'd3;
    tick();
    start = 1'b0;
    check("b0_busy", 32'(busy), 32'd1);
    check("b0_blank", 32'(blank_phase), 32'd1);
    nblank     = 1;
    prev_blank = blank_phase;
    for (int k = 1; k <= 12; k++) begin
      start       = (k == 4);
      burst_count = (k == 4) ? 4'd5 : 4'd3;
      tick();
      if (blank_phase && !prev_blank) nblank++;
      prev_blank = blank_phase;
      check("burst_blank", 32'(blank_phase),
            (k == 1 || k == 4 || k == 5 || k == 8 || k == 9) ? 32'd1 : 32'd0);
      check("burst_busy", 32'(busy), (k <= 9) ? 32'd1 : 32'd0);
      check("burst_done", 32'(done), (k == 10) ? 32'd1 : 32'd0);
      check("burst_anode", 32'(anode_out),
            (k == 1 || k == 2 || k == 5 || k == 6 || k == 9 || k == 10) ? 32'h3 : 32'h0);
    end
    start = 1'b0;
    check("burst_nblank", 32'(nblank), 32'd3);

    // 5: FAST, switch to SLOW mid-BLANK -> IDLE next cycle, then SLOW period
    mode = 2'b10;
    repeat (4) tick();
    check("fast_blank", 32'(blank_phase), 32'd1);
    mode = 2'b01;
    tick();
    check("abort_blank", 32'(blank_phase), 32'd0);
    check("abort_anode", 32'(anode_out), 32'h3);
    for (int j = 1; j <= 9; j++) begin
      tick();
      check("resume_blank", 32'(blank_phase), (j == 9) ? 32'd1 : 32'd0);
    end

    // 6a: start with burst_count=0 -> done pulse, busy stays 0
    mode = 2'b11;
    repeat (2) tick();
    check("z_idle_blank", 32'(blank_phase), 32'd0);
    start       = 1'b1;
    burst_count = 4'd0;
    tick();
    start = 1'b0;
    check("z_done", 32'(done), 32'd1);
    check("z_busy", 32'(busy), 32'd0);
    tick();
    check("z_done_low", 32'(done), 32'd0);
    check("z_busy_low", 32'(busy), 32'd0);

    // 6b: reset mid-burst -> immediate reset values, no done
    start       = 1'b1;
    burst_count = 4'd3;
    tick();
    start = 1'b0;
    tick();
    check("rb_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rb_anode", 32'(anode_out), 32'hF);
    check("rb_busy_clr", 32'(busy), 32'd0);
    check("rb_blank", 32'(blank_phase), 32'd0);
    check("rb_done", 32'(done), 32'd0);
    repeat (3) begin
      tick();
      check("rb_hold_done", 32'(done), 32'd0);
      check("rb_hold_anode", 32'(anode_out), 32'hF);
    end
    rst = 1'b0;
    tick();
    check("rb_rel_anode", 32'(anode_out), 32'h0);
    check("rb_rel_done", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
